// File: rtl/int_pkg.sv
// Shared definitions for the integer issue/execute block.
//   - opcode encodings for the ALU/shift unit
//   - tag and data widths
//   - result buffer entry layout {tag, data}
package int_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLLV = 4'd11;
    localparam logic [3:0] OP_SRLV = 4'd12;
    localparam logic [3:0] OP_SRAV = 4'd13;
    localparam logic [3:0] OP_LUI  = 4'd14;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rb_entry_t;

endpackage

// File: rtl/int_alu.sv
// Combinational integer ALU / shifter.
//   opcode_i  : operation select (see int_pkg)
//   shfamt_i  : immediate shift amount for SLL/SRL/SRA
//   rs_i      : first operand; rs_i[4:0] is the variable shift amount
//   rt_i      : second operand; the value being shifted
//   result_o  : 32-bit result (reserved opcode yields zero)
module int_alu
    import int_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [4:0]        shfamt_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (opcode_i)
            OP_ADD:  result_o = rs_i + rt_i;
            OP_SUB:  result_o = rs_i - rt_i;
            OP_AND:  result_o = rs_i & rt_i;
            OP_OR:   result_o = rs_i | rt_i;
            OP_XOR:  result_o = rs_i ^ rt_i;
            OP_NOR:  result_o = ~(rs_i | rt_i);
            OP_SLT:  result_o = {31'b0, ($signed(rs_i) < $signed(rt_i))};
            OP_SLTU: result_o = {31'b0, (rs_i < rt_i)};
            OP_SLL:  result_o = rt_i << shfamt_i;
            OP_SRL:  result_o = rt_i >> shfamt_i;
            OP_SRA:  result_o = $unsigned($signed(rt_i) >>> shfamt_i);
            OP_SLLV: result_o = rt_i << rs_i[4:0];
            OP_SRLV: result_o = rt_i >> rs_i[4:0];
            OP_SRAV: result_o = $unsigned($signed(rt_i) >>> rs_i[4:0]);
            OP_LUI:  result_o = {rt_i[15:0], 16'h0000};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/issue_unit_int.sv
// Integer issue/execute block.
// Accepts the oldest ready instruction from the integer issue queue, executes
// it in one cycle and parks the result in a 2-entry in-order buffer whose head
// is offered to the CDB arbiter.
//   Clk, Rst_n              : clock, async active-low reset
//   IssueQue_*              : instruction presented by the queue
//   Issueblk_Issue          : combinational accept back to the queue
//   Cdb_Grant               : arbiter takes the head entry this cycle
//   Int_Cdb_Req/Tag/Data    : head entry request, tag and result
//   RB_Flush_Valid          : discard buffered results, block issue
module issue_unit_int
    import int_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IssueQue_Ready,
    input  logic [DATA_W-1:0] IssueQue_Rs_Data,
    input  logic [DATA_W-1:0] IssueQue_Rt_Data,
    input  logic [TAG_W-1:0]  IssueQue_Rd_Tag,
    input  logic [3:0]        IssueQue_Opcode,
    input  logic [4:0]        IssueQue_Shfamt,
    output logic              Issueblk_Issue,
    input  logic              Cdb_Grant,
    output logic              Int_Cdb_Req,
    output logic [TAG_W-1:0]  Int_Cdb_Tag,
    output logic [DATA_W-1:0] Int_Cdb_Data,
    input  logic              RB_Flush_Valid
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]        cnt_q, cnt_d;
    rb_entry_t         buf_q [DEPTH];
    rb_entry_t         buf_d [DEPTH];
    logic [DATA_W-1:0] alu_result;
    rb_entry_t         new_entry;
    logic              pop;

    int_alu u_alu (
        .opcode_i (IssueQue_Opcode),
        .shfamt_i (IssueQue_Shfamt),
        .rs_i     (IssueQue_Rs_Data),
        .rt_i     (IssueQue_Rt_Data),
        .result_o (alu_result)
    );

    assign new_entry = '{tag: IssueQue_Rd_Tag, data: alu_result};

    assign Int_Cdb_Req  = (cnt_q != 2'd0);
    assign Int_Cdb_Tag  = buf_q[0].tag;
    assign Int_Cdb_Data = buf_q[0].data;

    assign pop = Cdb_Grant & Int_Cdb_Req;

    // A full buffer may still accept when its head leaves this cycle. Rst_n
    // gates the accept so the queue never sees one while reset is held.
    assign Issueblk_Issue = Rst_n & IssueQue_Ready & ~RB_Flush_Valid &
                            ((cnt_q < FULL) | pop);

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (RB_Flush_Valid) begin
            cnt_d = 2'd0;
        end else begin
            case ({Issueblk_Issue, pop})
                2'b10: begin
                    buf_d[cnt_q[0]] = new_entry;
                    cnt_d           = cnt_q + 2'd1;
                end
                2'b01: begin
                    // Draining the last entry leaves the head untouched so the
                    // outputs hold their last value while idle.
                    if (cnt_q == FULL) buf_d[0] = buf_q[1];
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == FULL) begin
                        buf_d[0] = buf_q[1];
                        buf_d[1] = new_entry;
                    end else begin
                        buf_d[0] = new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= 2'd0;
            buf_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: tb/tb_issue_unit_int.sv
module tb_issue_unit_int;
    import int_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        IssueQue_Ready;
    logic [31:0] IssueQue_Rs_Data;
    logic [31:0] IssueQue_Rt_Data;
    logic [4:0]  IssueQue_Rd_Tag;
    logic [3:0]  IssueQue_Opcode;
    logic [4:0]  IssueQue_Shfamt;
    logic        Issueblk_Issue;
    logic        Cdb_Grant;
    logic        Int_Cdb_Req;
    logic [4:0]  Int_Cdb_Tag;
    logic [31:0] Int_Cdb_Data;
    logic        RB_Flush_Valid;

    int checks   = 0;
    int failures = 0;

    issue_unit_int #(.DEPTH(2)) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .IssueQue_Ready   (IssueQue_Ready),
        .IssueQue_Rs_Data (IssueQue_Rs_Data),
        .IssueQue_Rt_Data (IssueQue_Rt_Data),
        .IssueQue_Rd_Tag  (IssueQue_Rd_Tag),
        .IssueQue_Opcode  (IssueQue_Opcode),
        .IssueQue_Shfamt  (IssueQue_Shfamt),
        .Issueblk_Issue   (Issueblk_Issue),
        .Cdb_Grant        (Cdb_Grant),
        .Int_Cdb_Req      (Int_Cdb_Req),
        .Int_Cdb_Tag      (Int_Cdb_Tag),
        .Int_Cdb_Data     (Int_Cdb_Data),
        .RB_Flush_Valid   (RB_Flush_Valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  shf;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic to_next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic gnt, input logic fl,
                         input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] shf,
                         input logic [4:0] tag);
        IssueQue_Ready   = rdy;
        Cdb_Grant        = gnt;
        RB_Flush_Valid   = fl;
        IssueQue_Opcode  = op;
        IssueQue_Rs_Data = rs;
        IssueQue_Rt_Data = rt;
        IssueQue_Shfamt  = shf;
        IssueQue_Rd_Tag  = tag;
    endtask

    // ADD with Rs = tag*10, Rt = 0 so each entry's data identifies its tag
    task automatic drive_add(input logic rdy, input logic gnt, input logic [4:0] tag);
        drive(rdy, gnt, 1'b0, OP_ADD, 32'(tag) * 32'd10, 32'd0, 5'd0, tag);
    endtask

    task automatic chk_head(input string name, input logic [4:0] tag);
        chk({name, "_req"},  {31'b0, Int_Cdb_Req}, 32'd1);
        chk({name, "_tag"},  {27'b0, Int_Cdb_Tag}, {27'b0, tag});
        chk({name, "_data"}, Int_Cdb_Data, 32'(tag) * 32'd10);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          5'd0,  5'd3,  32'd12};
        vecs[1]  = '{OP_SUB,  32'd5,          32'd7,          5'd0,  5'd4,  32'hFFFF_FFFE};
        vecs[2]  = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  5'd5,  32'hF000_F000};
        vecs[3]  = '{OP_OR,   32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  5'd6,  32'hFFF0_FFF0};
        vecs[4]  = '{OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  5'd7,  32'h0FF0_0FF0};
        vecs[5]  = '{OP_NOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  5'd8,  32'h000F_000F};
        vecs[6]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  5'd9,  32'd1};
        vecs[7]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  5'd10, 32'd0};
        vecs[8]  = '{OP_SLL,  32'd0,          32'd1,          5'd31, 5'd11, 32'h8000_0000};
        vecs[9]  = '{OP_SRL,  32'd0,          32'h8000_0000,  5'd4,  5'd12, 32'h0800_0000};
        vecs[10] = '{OP_SRA,  32'd0,          32'h8000_0000,  5'd4,  5'd13, 32'hF800_0000};
        vecs[11] = '{OP_SLLV, 32'h0000_0024,  32'd3,          5'd0,  5'd14, 32'h0000_0030};
        vecs[12] = '{OP_SRLV, 32'h0000_001F,  32'h8000_0000,  5'd9,  5'd15, 32'h0000_0001};
        vecs[13] = '{OP_SRAV, 32'h0000_0021,  32'h8000_0000,  5'd9,  5'd16, 32'hC000_0000};
        vecs[14] = '{OP_LUI,  32'h5555_5555,  32'h1234_ABCD,  5'd0,  5'd17, 32'hABCD_0000};
        vecs[15] = '{4'd15,   32'h1234_5678,  32'h9ABC_DEF0,  5'd3,  5'd18, 32'h0000_0000};

        Rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0, 5'd0);

        // reset state
        @(negedge Clk);
        chk("rst_req",   {31'b0, Int_Cdb_Req},    32'd0);
        chk("rst_tag",   {27'b0, Int_Cdb_Tag},    32'd0);
        chk("rst_data",  Int_Cdb_Data,            32'd0);
        chk("rst_issue", {31'b0, Issueblk_Issue}, 32'd0);
        to_next_cycle();
        Rst_n = 1'b1;

        // single-op vectors: issue into empty buffer, see result next cycle, pop
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].shf, vecs[i].tag);
            @(negedge Clk);
            chk($sformatf("vec%0d_issue", i), {31'b0, Issueblk_Issue}, 32'd1);
            to_next_cycle();
            drive(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0, 5'd0);
            @(negedge Clk);
            chk($sformatf("vec%0d_req", i),  {31'b0, Int_Cdb_Req}, 32'd1);
            chk($sformatf("vec%0d_tag", i),  {27'b0, Int_Cdb_Tag}, {27'b0, vecs[i].tag});
            chk($sformatf("vec%0d_data", i), Int_Cdb_Data, vecs[i].exp);
            to_next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0, 5'd0);
        @(negedge Clk);
        chk("drain_req", {31'b0, Int_Cdb_Req}, 32'd0);
        to_next_cycle();

        // backpressure: two issues, then stall, then one grant
        drive_add(1'b1, 1'b0, 5'd1);
        @(negedge Clk);
        chk("bp_issue1", {31'b0, Issueblk_Issue}, 32'd1);
        to_next_cycle();
        drive_add(1'b1, 1'b0, 5'd2);
        @(negedge Clk);
        chk("bp_issue2", {31'b0, Issueblk_Issue}, 32'd1);
        to_next_cycle();
        drive_add(1'b1, 1'b0, 5'd3);
        @(negedge Clk);
        chk("bp_full_issue", {31'b0, Issueblk_Issue}, 32'd0);
        chk_head("bp_head1", 5'd1);
        to_next_cycle();
        @(negedge Clk);
        chk("bp_still_full", {31'b0, Issueblk_Issue}, 32'd0);
        to_next_cycle();
        drive_add(1'b1, 1'b1, 5'd3);
        @(negedge Clk);
        chk("bp_grant_issue", {31'b0, Issueblk_Issue}, 32'd1);
        to_next_cycle();
        drive_add(1'b0, 1'b1, 5'd0);
        @(negedge Clk);
        chk_head("bp_head2", 5'd2);
        to_next_cycle();
        @(negedge Clk);
        chk_head("bp_head3", 5'd3);
        to_next_cycle();
        drive_add(1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        chk("bp_empty_req", {31'b0, Int_Cdb_Req}, 32'd0);
        chk("bp_empty_hold_tag", {27'b0, Int_Cdb_Tag}, 32'd3);
        to_next_cycle();

        // grant with nothing buffered is ignored
        drive_add(1'b0, 1'b1, 5'd0);
        to_next_cycle();
        drive_add(1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        chk("idle_grant_req", {31'b0, Int_Cdb_Req}, 32'd0);
        to_next_cycle();

        // simultaneous push/pop at cnt=1
        drive_add(1'b1, 1'b0, 5'd4);
        to_next_cycle();
        drive_add(1'b1, 1'b1, 5'd5);
        @(negedge Clk);
        chk_head("pp_head4", 5'd4);
        chk("pp_issue", {31'b0, Issueblk_Issue}, 32'd1);
        to_next_cycle();
        drive_add(1'b0, 1'b1, 5'd0);
        @(negedge Clk);
        chk_head("pp_head5", 5'd5);
        to_next_cycle();
        drive_add(1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        chk("pp_cnt_was1", {31'b0, Int_Cdb_Req}, 32'd0);
        to_next_cycle();

        // flush at cnt=2 with ready and grant
        drive_add(1'b1, 1'b0, 5'd6);
        to_next_cycle();
        drive_add(1'b1, 1'b0, 5'd7);
        to_next_cycle();
        drive_add(1'b1, 1'b1, 5'd8);
        RB_Flush_Valid = 1'b1;
        @(negedge Clk);
        chk("fl_issue", {31'b0, Issueblk_Issue}, 32'd0);
        chk_head("fl_head", 5'd6);
        to_next_cycle();
        drive_add(1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        chk("fl_req_after", {31'b0, Int_Cdb_Req}, 32'd0);
        to_next_cycle();

        // async reset mid-cycle at cnt=2
        drive_add(1'b1, 1'b0, 5'd8);
        to_next_cycle();
        drive_add(1'b1, 1'b0, 5'd9);
        to_next_cycle();
        drive_add(1'b1, 1'b0, 5'd10);
        @(negedge Clk);
        chk_head("ar_head_before", 5'd8);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_req_drop",  {31'b0, Int_Cdb_Req},    32'd0);
        chk("ar_tag_clear", {27'b0, Int_Cdb_Tag},    32'd0);
        chk("ar_issue",     {31'b0, Issueblk_Issue}, 32'd0);
        to_next_cycle();
        Rst_n = 1'b1;
        drive_add(1'b1, 1'b0, 5'd10);
        @(negedge Clk);
        chk("ar_issue_after", {31'b0, Issueblk_Issue}, 32'd1);
        to_next_cycle();
        drive_add(1'b0, 1'b1, 5'd0);
        @(negedge Clk);
        chk_head("ar_head_after", 5'd10);
        to_next_cycle();
        drive_add(1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        chk("ar_single_entry", {31'b0, Int_Cdb_Req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
